// File: rtl/truth_table_sweeper.sv
// Sweeps a 5-input function through codes 0..31, settling each code before capturing y_in into a truth table.
// Optional compare port set enabled by defining TRUTH_TABLE_SWEEPER_COMPARE_EN.
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        y_in,
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
    input  logic [31:0] expected,
    output logic        mismatch,
    output logic [4:0]  first_bad,
`endif
    output logic [4:0]  x_out,
    output logic [31:0] truth_table,
    output logic [5:0]  ones_count,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  count;
    logic [7:0]  count_nxt;
    logic [4:0]  x_nxt;
    logic [31:0] tt_nxt;
    logic [5:0]  ones_nxt;
    logic        busy_nxt;
    logic        done_nxt;

`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
    logic [31:0] exp_reg;
    logic [31:0] exp_nxt;
    logic        mismatch_nxt;
    logic [4:0]  first_bad_nxt;
`endif

    // Next-state and next-output computation; busy/done are precomputed so they leave flops.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        x_nxt     = x_out;
        tt_nxt    = truth_table;
        ones_nxt  = ones_count;
        busy_nxt  = busy;
        done_nxt  = done;
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
        exp_nxt       = exp_reg;
        mismatch_nxt  = mismatch;
        first_bad_nxt = first_bad;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = SETTLE;
                    count_nxt = 8'd0;
                    x_nxt     = 5'd0;
                    tt_nxt    = 32'd0;
                    ones_nxt  = 6'd0;
                    busy_nxt  = 1'b1;
                    done_nxt  = 1'b0;
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
                    exp_nxt       = expected;
                    mismatch_nxt  = 1'b0;
                    first_bad_nxt = 5'd0;
`endif
                end else begin
                    state_nxt = state;
                end
            end
            SETTLE: begin
                count_nxt = count + 8'd1;
                if (count == SETTLE_LAST) begin
                    state_nxt = SAMPLE;
                end else begin
                    state_nxt = SETTLE;
                end
            end
            SAMPLE: begin
                tt_nxt[x_out] = y_in;
                ones_nxt      = ones_count + {5'd0, y_in};
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
                if (y_in != exp_reg[x_out]) begin
                    mismatch_nxt  = 1'b1;
                    first_bad_nxt = mismatch ? first_bad : x_out;
                end else begin
                    mismatch_nxt  = mismatch;
                    first_bad_nxt = first_bad;
                end
`endif
                // The last code parks at 31 rather than wrapping to 0.
                if (x_out == 5'd31) begin
                    state_nxt = DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = SETTLE;
                    x_nxt     = x_out + 5'd1;
                    count_nxt = 8'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b0;
            end
        endcase
    end

    // State, counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= 8'd0;
            x_out       <= 5'd0;
            truth_table <= 32'd0;
            ones_count  <= 6'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            x_out       <= x_nxt;
            truth_table <= tt_nxt;
            ones_count  <= ones_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
    // Golden table latch and sticky mismatch tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_reg   <= 32'd0;
            mismatch  <= 1'b0;
            first_bad <= 5'd0;
        end else begin
            exp_reg   <= exp_nxt;
            mismatch  <= mismatch_nxt;
            first_bad <= first_bad_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized self-checking bench for truth_table_sweeper against a cycle-indexed reference model.
module tb_truth_table_sweeper;

    localparam int S = 4;
    localparam int P = S + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        y_in = 1'b0;
    logic [4:0]  x_out;
    logic [31:0] truth_table;
    logic [5:0]  ones_count;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
    logic [31:0] golden = 32'd0;
    logic        mismatch;
    logic [4:0]  first_bad;
    bit          custom_gold = 1'b0;
`endif

    truth_table_sweeper #(.SETTLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .y_in        (y_in),
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
        .expected    (golden),
        .mismatch    (mismatch),
        .first_bad   (first_bad),
`endif
        .x_out       (x_out),
        .truth_table (truth_table),
        .ones_count  (ones_count),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected outputs n edges after the start edge, derived from the capture schedule.
    task automatic check_state(input string tag, input int n, input logic [31:0] tt);
        int          captured;
        int          ex;
        logic [31:0] mask;
        logic [31:0] etab;
        captured = n / P;
        ex       = (captured > 31) ? 31 : captured;
        mask     = (captured >= 32) ? 32'hFFFF_FFFF : ((32'd1 << captured) - 32'd1);
        etab     = tt & mask;
        check({tag, ".x_out"}, {27'd0, x_out}, ex);
        check({tag, ".truth_table"}, truth_table, etab);
        check({tag, ".ones_count"}, {26'd0, ones_count}, $countones(etab));
        check({tag, ".busy"}, {31'd0, busy}, (n < 32 * P) ? 32'd1 : 32'd0);
        check({tag, ".done"}, {31'd0, done}, (n >= 32 * P) ? 32'd1 : 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".x_out"}, {27'd0, x_out}, 32'd0);
        check({tag, ".truth_table"}, truth_table, 32'd0);
        check({tag, ".ones_count"}, {26'd0, ones_count}, 32'd0);
        check({tag, ".busy"}, {31'd0, busy}, 32'd0);
        check({tag, ".done"}, {31'd0, done}, 32'd0);
    endtask

    // One sweep of function tt; y_in carries noise except right before each capture edge.
    task automatic sweep(input string tag, input logic [31:0] tt, input int busy_start_at, input int abort_at);
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
        int fb;
        if (!custom_gold) golden = tt;
`endif
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 0; n <= 32 * P; n++) begin
            check_state(tag, n, tt);
            if (n == abort_at) begin
                #2 rst = 1'b1;
                #1 check_idle({tag, ".async_rst"});
                @(negedge clk);
                rst = 1'b0;
                repeat (4) @(posedge clk);
                #1 check_idle({tag, ".post_rst"});
                return;
            end
            if (n == 32 * P) break;
            if (((n + 1) % P) == 0) y_in = tt[(n + 1) / P - 1];
            else y_in = 1'($urandom);
            start = (n == busy_start_at);
            @(posedge clk);
            #1;
        end
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
        fb = 0;
        for (int i = 31; i >= 0; i--) if (tt[i] != golden[i]) fb = i;
        check({tag, ".mismatch"}, {31'd0, mismatch}, (tt != golden) ? 32'd1 : 32'd0);
        check({tag, ".first_bad"}, {27'd0, first_bad}, fb);
`endif
    endtask

    initial begin
        logic [31:0] r;
        repeat (2) @(posedge clk);
        #1 check_idle("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_idle("idle_no_start");

        sweep("zero", 32'h0000_0000, -1, -1);
        sweep("x0", 32'hAAAA_AAAA, -1, -1);
        sweep("parity", 32'h9669_6996, -1, -1);
        repeat (3) @(posedge clk);
        #1 check_state("done_hold", 32 * P, 32'h9669_6996);
        sweep("parity_again", 32'h9669_6996, -1, -1);
        sweep("ones_busy_start", 32'hFFFF_FFFF, 36, -1);
        sweep("abort", 32'h1234_5678, -1, 10 * P + 2);
        for (int k = 0; k < 3; k++) begin
            r = $urandom;
            sweep("random", r, (k == 1) ? 90 : -1, -1);
        end
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
        custom_gold = 1'b1;
        golden = 32'hAAAA_AAAA;
        sweep("compare", 32'hAAAA_AA8A, -1, -1);
        custom_gold = 1'b0;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
